// File: rtl/sdrx_blkframe.sv
// SD receive block framer: finds the start bit, deserialises 1/4/8-lane data into 32-bit words,
// checks per-lane CRC16 (SDR or DDR A/B sets) and the end bit, then reports completion status.
module sdrx_blkframe #(
   parameter int NUMIO    = 8,
   parameter int LGMAXBLK = 9
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_rx_en,
   input  logic [1:0]  i_cfg_width,
   input  logic        i_cfg_ddr,
   input  logic [3:0]  i_cfg_lgblk,
   input  logic [1:0]  i_rx_strb,
   input  logic [15:0] i_rx_data,
   output logic        o_valid,
   output logic [31:0] o_data,
   output logic        o_last,
   output logic        o_done,
   output logic [7:0]  o_crc_err,
   output logic        o_end_err,
   output logic        o_busy
);

   localparam int CW = LGMAXBLK + 4;
   localparam logic [8:0] LANE_ONE = 9'd1;
   localparam logic [7:0] LANE_MASK = 8'((LANE_ONE << NUMIO) - LANE_ONE);
   localparam logic [3:0] LG_MAX = 4'(LGMAXBLK);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_CRC  = 3'd3;
   localparam logic [2:0] S_END  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   // lgl holds log2 of the lane count (0, 2 or 3) latched at the start bit
   typedef struct packed {
      logic [2:0]       st;
      logic [CW-1:0]    cnt;
      logic [1:0]       lgl;
      logic             ddr;
      logic [3:0]       lgblk;
      logic [31:0]      shreg;
      logic [7:0][15:0] crc_a;
      logic [7:0][15:0] crc_b;
      logic [7:0]       err;
      logic             end_err;
   } fr_t;

   typedef struct packed {
      fr_t         f;
      logic        wv;
      logic [31:0] wd;
      logic        wl;
      logic        dn;
   } res_t;

   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
   endfunction

   // Advance the framer by exactly one sample.
   function automatic res_t step(input fr_t c, input logic [7:0] raw, input logic [1:0] cw,
                                 input logic cddr, input logic [3:0] clg);
      res_t          r;
      logic [7:0]    s;
      logic [7:0]    act;
      logic [CW-1:0] wmask;
      logic [CW-1:0] last_cnt;
      logic [4:0]    sh;
      logic          set_b;
      r     = '0;
      r.f   = c;
      r.wd  = c.shreg;
      s     = raw | ~LANE_MASK;
      case (c.lgl)
         2'd2:    begin act = 8'h0f; wmask = CW'(7);  end
         2'd3:    begin act = 8'hff; wmask = CW'(3);  end
         default: begin act = 8'h01; wmask = CW'(31); end
      endcase
      set_b    = c.ddr & c.cnt[0];
      sh       = 5'(c.lgblk) + 5'd3 - 5'(c.lgl);
      last_cnt = (CW'(1) << sh) - CW'(1);
      case (c.st)
         S_WAIT: begin
            if (!s[0]) begin
               r.f    = '0;
               r.f.st = S_DATA;
               case (cw)
                  2'd1:    r.f.lgl = 2'd2;
                  2'd2:    r.f.lgl = 2'd3;
                  default: r.f.lgl = 2'd0;
               endcase
               r.f.ddr = cddr;
               if (clg < 4'd2)
                  r.f.lgblk = 4'd2;
               else if (clg > LG_MAX)
                  r.f.lgblk = LG_MAX;
               else
                  r.f.lgblk = clg;
            end
         end
         S_DATA: begin
            case (c.lgl)
               2'd2:    r.f.shreg = {c.shreg[27:0], s[3:0]};
               2'd3:    r.f.shreg = {c.shreg[23:0], s};
               default: r.f.shreg = {c.shreg[30:0], s[0]};
            endcase
            for (int k = 0; k < 8; k++) begin
               if (act[k]) begin
                  if (set_b)
                     r.f.crc_b[k] = crc_bit(c.crc_b[k], s[k]);
                  else
                     r.f.crc_a[k] = crc_bit(c.crc_a[k], s[k]);
               end
            end
            if ((c.cnt & wmask) == wmask) begin
               r.wv = 1'b1;
               r.wd = r.f.shreg;
            end
            if (c.cnt == last_cnt) begin
               r.wl    = 1'b1;
               r.f.st  = S_CRC;
               r.f.cnt = '0;
            end else begin
               r.f.cnt = c.cnt + CW'(1);
            end
         end
         S_CRC: begin
            // Received CRC bits are compared against the computed MSB, which is then shifted out
            for (int k = 0; k < 8; k++) begin
               if (act[k]) begin
                  if (set_b) begin
                     r.f.err[k]   = c.err[k] | (s[k] ^ c.crc_b[k][15]);
                     r.f.crc_b[k] = {c.crc_b[k][14:0], 1'b0};
                  end else begin
                     r.f.err[k]   = c.err[k] | (s[k] ^ c.crc_a[k][15]);
                     r.f.crc_a[k] = {c.crc_a[k][14:0], 1'b0};
                  end
               end
            end
            if (c.cnt == (c.ddr ? CW'(31) : CW'(15))) begin
               r.f.st  = S_END;
               r.f.cnt = '0;
            end else begin
               r.f.cnt = c.cnt + CW'(1);
            end
         end
         S_END: begin
            r.f.end_err = (s & act) != act;
            r.f.st      = S_DONE;
            r.dn        = 1'b1;
         end
         default: ;
      endcase
      return r;
   endfunction

   fr_t         fr_reg;
   fr_t         fr_next;
   res_t        r_hi;
   res_t        r_lo;
   logic        wv_next;
   logic [31:0] wd_next;
   logic        wl_next;
   logic        dn_next;

   always_comb begin
      fr_next = fr_reg;
      r_hi    = '0;
      r_lo    = '0;
      wv_next = 1'b0;
      wd_next = o_data;
      wl_next = 1'b0;
      dn_next = 1'b0;
      if (fr_reg.st == S_IDLE) begin
         if (i_rx_en)
            fr_next.st = S_WAIT;
      end else if (!i_rx_en) begin
         fr_next = '0;
      end else if (fr_reg.st == S_DONE) begin
         fr_next.st = S_WAIT;
      end else begin
         // Earlier sample first, so a state change it causes governs the later one
         r_hi.f = fr_reg;
         if (i_rx_strb[1])
            r_hi = step(fr_reg, i_rx_data[15:8], i_cfg_width, i_cfg_ddr, i_cfg_lgblk);
         r_lo.f = r_hi.f;
         if (i_rx_strb == 2'b11)
            r_lo = step(r_hi.f, i_rx_data[7:0], i_cfg_width, i_cfg_ddr, i_cfg_lgblk);
         fr_next = r_lo.f;
         wv_next = r_hi.wv | r_lo.wv;
         wd_next = r_lo.wv ? r_lo.wd : r_hi.wd;
         wl_next = r_hi.wl | r_lo.wl;
         dn_next = r_hi.dn | r_lo.dn;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         fr_reg    <= '0;
         o_valid   <= 1'b0;
         o_data    <= 32'h0;
         o_last    <= 1'b0;
         o_done    <= 1'b0;
         o_crc_err <= 8'h00;
         o_end_err <= 1'b0;
      end else begin
         fr_reg  <= fr_next;
         o_valid <= wv_next;
         if (wv_next)
            o_data <= wd_next;
         o_last    <= wv_next & wl_next;
         o_done    <= dn_next;
         o_crc_err <= dn_next ? fr_next.err : 8'h00;
         o_end_err <= dn_next & fr_next.end_err;
      end
   end

   assign o_busy = (fr_reg.st != S_IDLE);

endmodule

// File: tb/tb_sdrx_blkframe.sv
// Directed bench for sdrx_blkframe: builds sample streams with bench-computed CRCs and
// checks words and completion status through an expectation scoreboard.
module tb_sdrx_blkframe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_en;
   logic [1:0]  cfg_width;
   logic        cfg_ddr;
   logic [3:0]  cfg_lgblk;
   logic [1:0]  strb;
   logic [15:0] data;
   logic        o_valid;
   logic [31:0] o_data;
   logic        o_last;
   logic        o_done;
   logic [7:0]  o_crc_err;
   logic        o_end_err;
   logic        o_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]  byte_q[$];
   logic [7:0]  samp_q[$];
   logic [31:0] exp_word_q[$];
   logic        exp_last_q[$];
   logic [7:0]  exp_crc_q[$];
   logic        exp_end_q[$];

   logic [31:0] m_w;
   logic        m_l;
   logic [7:0]  m_c;
   logic        m_e;

   always #5 clk = ~clk;

   sdrx_blkframe #(.NUMIO(8), .LGMAXBLK(9)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_rx_en    (rx_en),
      .i_cfg_width(cfg_width),
      .i_cfg_ddr  (cfg_ddr),
      .i_cfg_lgblk(cfg_lgblk),
      .i_rx_strb  (strb),
      .i_rx_data  (data),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_last     (o_last),
      .o_done     (o_done),
      .o_crc_err  (o_crc_err),
      .o_end_err  (o_end_err),
      .o_busy     (o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      logic fb;
      fb = b ^ c[15];
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // Turns byte_q into a start/data/CRC/end sample stream and queues the expected results.
   task automatic build_frame(input int lanes, input bit ddr, input int flip_lane, input bit end_ok);
      logic [15:0] ca [8];
      logic [15:0] cb [8];
      logic [7:0]  ds[$];
      logic [7:0]  s;
      logic [7:0]  bv;
      int          nw;
      for (int k = 0; k < 8; k++) begin
         ca[k] = 16'h0;
         cb[k] = 16'h0;
      end
      for (int b = 0; b < byte_q.size(); b++) begin
         bv = byte_q[b];
         if (lanes == 1) begin
            for (int j = 7; j >= 0; j--) begin
               s = 8'hfe | {7'b0, bv[j]};
               ds.push_back(s);
            end
         end else if (lanes == 4) begin
            ds.push_back({4'hf, bv[7:4]});
            ds.push_back({4'hf, bv[3:0]});
         end else begin
            ds.push_back(bv);
         end
      end
      samp_q.push_back(8'h00);
      for (int i = 0; i < ds.size(); i++) begin
         s = ds[i];
         for (int k = 0; k < lanes; k++) begin
            if (ddr && (i % 2 == 1))
               cb[k] = crc_bit(cb[k], s[k]);
            else
               ca[k] = crc_bit(ca[k], s[k]);
         end
         samp_q.push_back(s);
      end
      if (flip_lane >= 0) begin
         if (ddr)
            cb[flip_lane][0] = ~cb[flip_lane][0];
         else
            ca[flip_lane][0] = ~ca[flip_lane][0];
      end
      for (int j = 0; j < (ddr ? 32 : 16); j++) begin
         s = 8'hff;
         for (int k = 0; k < lanes; k++) begin
            if (ddr)
               s[k] = (j % 2 == 1) ? cb[k][15 - j/2] : ca[k][15 - j/2];
            else
               s[k] = ca[k][15 - j];
         end
         samp_q.push_back(s);
      end
      samp_q.push_back(end_ok ? 8'hff : 8'hfe);
      nw = byte_q.size() / 4;
      for (int w = 0; w < nw; w++) begin
         exp_word_q.push_back({byte_q[4*w], byte_q[4*w+1], byte_q[4*w+2], byte_q[4*w+3]});
         exp_last_q.push_back(w == nw - 1);
      end
      exp_crc_q.push_back(flip_lane >= 0 ? 8'(1 << flip_lane) : 8'h00);
      exp_end_q.push_back(!end_ok);
      byte_q.delete();
   endtask

   task automatic send(input int per);
      logic [7:0] a;
      logic [7:0] b;
      while (samp_q.size() > 0) begin
         @(posedge clk); #1;
         if (per == 2 && samp_q.size() >= 2) begin
            a = samp_q.pop_front();
            b = samp_q.pop_front();
            strb = 2'b11;
            data = {a, b};
         end else begin
            a = samp_q.pop_front();
            strb = 2'b10;
            data = {a, 8'($urandom)};
         end
      end
      @(posedge clk); #1;
      strb = 2'b00;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (exp_word_q.size() == 0 && exp_crc_q.size() == 0)
            break;
         @(posedge clk);
      end
      chk(tag, exp_word_q.size() + exp_crc_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // Scoreboard: every word and every completion must match the next queued expectation
   always @(negedge clk) begin
      if (o_valid) begin
         if (exp_word_q.size() == 0) begin
            chk("spurious_valid", {31'b0, o_valid}, 32'd0);
         end else begin
            m_w = exp_word_q.pop_front();
            m_l = exp_last_q.pop_front();
            chk("word_data", o_data, m_w);
            chk("word_last", {31'b0, o_last}, {31'b0, m_l});
            $display("word  data=%h last=%0d (want %h/%0d)", o_data, o_last, m_w, m_l);
         end
      end
      if (o_done) begin
         if (exp_crc_q.size() == 0) begin
            chk("spurious_done", {31'b0, o_done}, 32'd0);
         end else begin
            m_c = exp_crc_q.pop_front();
            m_e = exp_end_q.pop_front();
            chk("crc_err", {24'b0, o_crc_err}, {24'b0, m_c});
            chk("end_err", {31'b0, o_end_err}, {31'b0, m_e});
            $display("done  crc_err=%h end_err=%0d (want %h/%0d)", o_crc_err, o_end_err, m_c, m_e);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      rx_en     = 1'b0;
      cfg_width = 2'd0;
      cfg_ddr   = 1'b0;
      cfg_lgblk = 4'd2;
      strb      = 2'b00;
      data      = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, o_valid}, 32'd0);
      chk("rst_data", o_data, 32'd0);
      chk("rst_last", {31'b0, o_last}, 32'd0);
      chk("rst_done", {31'b0, o_done}, 32'd0);
      chk("rst_crc_err", {24'b0, o_crc_err}, 32'd0);
      chk("rst_end_err", {31'b0, o_end_err}, 32'd0);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rx_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("armed_busy", {31'b0, o_busy}, 32'd1);

      // 1 lane SDR, 4 bytes, one sample per cycle
      cfg_width = 2'd0; cfg_ddr = 1'b0; cfg_lgblk = 4'd2;
      byte_q = '{8'hde, 8'had, 8'hbe, 8'hef};
      build_frame(1, 1'b0, -1, 1'b1);
      send(1);
      drain("drain_t1");

      // 4 lanes SDR, 8 bytes, two samples per cycle, start bit in the upper sample
      cfg_width = 2'd1; cfg_lgblk = 4'd3;
      byte_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      build_frame(4, 1'b0, -1, 1'b1);
      send(2);
      drain("drain_t2");

      // 8 lanes DDR, lane 5 set B CRC corrupted, start bit in the lower sample
      cfg_width = 2'd2; cfg_ddr = 1'b1; cfg_lgblk = 4'd2;
      samp_q.push_back(8'hff);
      byte_q = '{8'hc3, 8'h5a, 8'h96, 8'h0f};
      build_frame(8, 1'b1, 5, 1'b1);
      send(2);
      drain("drain_t3");

      // width code 3 acts as 1 lane, lgblk 1 clamps to 4 bytes, end bit low
      cfg_width = 2'd3; cfg_ddr = 1'b0; cfg_lgblk = 4'd1;
      byte_q = '{8'h12, 8'h34, 8'h56, 8'h78};
      build_frame(1, 1'b0, -1, 1'b0);
      send(1);
      drain("drain_t4");

      // abort after 2 of 8 bytes, then a fresh frame
      cfg_width = 2'd1; cfg_lgblk = 4'd3;
      samp_q = '{8'h00, 8'hfa, 8'hf5, 8'hf3, 8'hfc};
      send(1);
      chk("abort_busy_before", {31'b0, o_busy}, 32'd1);
      @(posedge clk); #1;
      rx_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy_after", {31'b0, o_busy}, 32'd0);
      chk("abort_valid", {31'b0, o_valid}, 32'd0);
      chk("abort_done", {31'b0, o_done}, 32'd0);
      rx_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cfg_lgblk = 4'd2;
      byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      build_frame(4, 1'b0, -1, 1'b1);
      send(1);
      drain("drain_t5");

      // back-to-back frames with illegal 2'b01 strobes in between
      cfg_width = 2'd2; cfg_ddr = 1'b0; cfg_lgblk = 4'd3;
      for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
      build_frame(8, 1'b0, -1, 1'b1);
      send(2);
      cfg_width = 2'd0; cfg_ddr = 1'b1; cfg_lgblk = 4'd2;
      repeat (4) begin
         @(posedge clk); #1;
         strb = 2'b01;
         data = 16'h0000;
      end
      @(posedge clk); #1;
      strb = 2'b00;
      chk("b2b_busy", {31'b0, o_busy}, 32'd1);
      for (int i = 0; i < 4; i++) byte_q.push_back(8'($urandom));
      build_frame(1, 1'b1, -1, 1'b1);
      send(2);
      drain("drain_t6");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdrx_blkframe.md
Name: sdrx_blkframe

Overview:
- Receive-side data framer directly downstream of the SD I/O front end.
- Consumes the front end's synchronous two-sample strobe/data path (`i_rx_strb`/`i_rx_data`).
- For each block: finds the start bit, deserialises 1/4/8-lane data into 32-bit big-endian words, checks per-lane CRC16 (SDR or DDR) and the end bit, then reports completion and error status.

Parameters:
- `NUMIO`, 8: number of physical data lanes (1, 4 or 8); lanes at or above `NUMIO` are treated as constant 1.
- `LGMAXBLK`, 9: log2 of the maximum block length in bytes; sets the byte-counter width.

Ports:
- `i_clk`  in  1  system clock, same domain as the front end.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_rx_en`  in  1  arm receiver; deassertion aborts.
- `i_cfg_width`  in  2  lane width: 0 = 1 lane, 1 = 4 lanes, 2 = 8 lanes; 3 is treated as 1 lane.
- `i_cfg_ddr`  in  1  DDR CRC mode.
- `i_cfg_lgblk`  in  4  log2 of block bytes; clamped to the range 2..`LGMAXBLK`.
- `i_rx_strb`  in  2  bit [1] = sample in `i_rx_data[15:8]`; bit [0] = second, later sample in `i_rx_data[7:0]`. Bit [0] is only meaningful when bit [1] is set.
- `i_rx_data`  in  16  two 8-lane samples; lane k of a sample is bit k of its byte.
- `o_valid`  out  1  word strobe.
- `o_data`  out  32  assembled word; first received byte is in [31:24].
- `o_last`  out  1  final word of the block, qualified by `o_valid`.
- `o_done`  out  1  one-cycle pulse when the frame completes.
- `o_crc_err`  out  8  per-lane CRC mismatch mask; valid while `o_done` is high.
- `o_end_err`  out  1  end bit not 1 on every active lane; valid while `o_done` is high.
- `o_busy`  out  1  high in every state other than IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters and CRC registers 0.
- Sample ordering: within one cycle, sample [15:8] is processed completely (including any state transition it causes) before sample [7:0].
- Active lanes: lane 0 (1-bit mode), lanes 3:0 (4-bit mode), lanes 7:0 (8-bit mode).
- States:
  - IDLE: if `i_rx_en` is high, go to WAIT_START on the next cycle.
  - WAIT_START: leave on the first sample with lane 0 = 0. That sample is the start bit and is not data or CRC. If it is the [15:8] sample, the [7:0] sample of the same cycle is the first data sample.
  - DATA: shift samples in.
    - 1 lane: MSB first; 8 samples per byte.
    - 4 lanes: sample = nibble with lane 3 as MSB; high nibble first.
    - 8 lanes: sample = byte with lane 7 as MSB.
    - Bytes pack into [31:24], [23:16], [15:8], [7:0] in arrival order.
    - Leave after 2^lgblk bytes.
  - CRC: each active lane receives a 16-bit CRC, MSB first.
    - SDR: 16 samples.
    - DDR: 32 samples. Even-numbered samples (counted from the first data sample, index 0) feed CRC set A; odd-numbered samples feed set B. CRC bits arrive interleaved A, B, A, B, …, MSB first.
  - END: one sample; check that every active lane = 1.
  - DONE: assert `o_done` for one cycle, then return to WAIT_START if `i_rx_en` is still high, otherwise IDLE.
- CRC: polynomial x^16+x^12+x^5+1 (0x1021), initial value 0, computed per lane (per lane and per set in DDR) over data samples only.
  - A lane's error bit is set if its received CRC differs from the computed value (either set, in DDR).
  - Inactive lanes report 0.
- Word output: `o_valid` rises the cycle after the strobe that completes a word. `o_data` holds until the next `o_valid`. There is no backpressure.
- Block lengths of 4 bytes or more are always a whole number of words; `o_last` is set with the final word.
- Completion timing: `o_done`, `o_crc_err` and `o_end_err` are registered the cycle after the END sample. `o_crc_err` and `o_end_err` return to 0 when `o_done` falls.
- Two samples in one cycle may straddle a state boundary (data→CRC, CRC→END, END→DONE). When END is the [15:8] sample, the [7:0] sample is discarded.
- Configuration inputs are sampled on the WAIT_START→DATA transition and ignored while a block is in progress.
- Abort: `i_rx_en` low in any non-IDLE state → IDLE on the next cycle. No `o_done`; any pending `o_valid` is suppressed; counters and CRCs are cleared.
- Asynchronous reset mid-frame: immediate return to the reset state.
- `i_rx_strb` = 2'b01 is an illegal combination and is ignored.

Test Plan:
- 1 lane, SDR, lgblk=2, one sample per cycle, data 0xDEADBEEF plus bench-computed CRC and end=1 → one `o_valid` with `o_data`=32'hDEADBEEF and `o_last`=1; then `o_done`=1, `o_crc_err`=0, `o_end_err`=0.
- 4 lanes, SDR, lgblk=3, two samples per cycle, bytes 00..07, start bit in the [15:8] sample → words 32'h00010203 then 32'h04050607 (`o_last` set on the second); clean `o_done`.
- 8 lanes, DDR, lgblk=2, correct A/B CRCs except lane 5 set B with bit 0 flipped → `o_crc_err`=8'h20, `o_end_err`=0, data word still delivered.
- 1 lane, SDR, correct CRC, end bit driven to 0 → `o_done` with `o_end_err`=1 and `o_crc_err`=0.
- `i_rx_en` dropped after 2 of 8 bytes → `o_busy`=0 next cycle, no `o_valid`/`o_done`. Re-arm with a fresh lgblk=2 frame → correct word, proving state was cleared.
- Back-to-back frames with `i_rx_en` held high and `i_rx_strb`=2'b01 glitches between them → both frames decoded and the glitches ignored.
